vs_fp_dot: RTL and testbench

Streaming signed fixed-point dot-product engine. It accepts a programmed number of (a, b) operand pairs over a valid/ready stream and accumulates their full-precision products in a 64-bit register. At the end it returns one Q-format 32-bit result, saturated, through a valid/ready output. It replaces a free-running MAC in datapaths that need a framed, backpressure-aware inner product, for example correlation and projection steps in the sparse solvers.

---
 rtl/vs_fp_dot.sv | 122 ++++++++++++
 tb/tb_vs_fp_dot.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vs_fp_dot.sv
// vs_fp_dot: framed, backpressure-aware signed fixed-point dot product.
// 64-bit wrapping accumulator; the Q-format result is clipped to a symmetric range.
module vs_fp_dot #(
    parameter int Q     = 15,
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a_in,
    input  logic [31:0]      b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    typedef struct packed {
        logic [31:0] value;
        logic        clipped;
    } sat_t;

    // Symmetric limits: the most negative code 0x80000000 is never produced.
    localparam logic signed [63:0] POS_LIM = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] NEG_LIM = -POS_LIM;

    state_t             state;
    logic signed [63:0] acc;
    logic signed [63:0] product;
    logic signed [63:0] acc_sum;
    logic signed [63:0] scaled;
    logic [LEN_W-1:0]   count;
    logic               beat;
    sat_t               final_q;

    assign beat = in_valid & in_ready;

    always_comb begin
        // NOTE: every output of this block is assigned up front so no path
        // leaves a variable holding its old value, which would infer a latch.
        product = $signed({{32{a_in[31]}}, a_in}) * $signed({{32{b_in[31]}}, b_in});
        acc_sum = acc + product;
        scaled  = acc_sum >>> Q;
        final_q = '{value: scaled[31:0], clipped: 1'b0};
        if (scaled > POS_LIM) begin
            final_q = '{value: 32'h7FFF_FFFF, clipped: 1'b1};
        end else if (scaled < NEG_LIM) begin
            final_q = '{value: 32'h8000_0001, clipped: 1'b1};
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            acc      <= '0;
                            count    <= length;
                            in_ready <= 1'b1;
                            state    <= ACCUM;
                        end else begin
                            result    <= '0;
                            overflow  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                ACCUM: begin
                    if (beat) begin
                        acc   <= acc_sum;
                        count <= count - LEN_W'(1);
                        // The last beat converts the updated sum, not the stale register.
                        if (count == LEN_W'(1)) begin
                            result    <= final_q.value;
                            overflow  <= final_q.clipped;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vs_fp_dot.sv
// tb_vs_fp_dot: directed and randomized frames checked against a queue-based
// arithmetic model of the dot product, plus hand-computed literal results.
module tb_vs_fp_dot;

    localparam int Q     = 15;
    localparam int LEN_W = 16;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b1;
    logic             start     = 1'b0;
    logic [LEN_W-1:0] length    = '0;
    logic             in_valid  = 1'b0;
    logic [31:0]      a_in      = '0;
    logic [31:0]      b_in      = '0;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      result;
    logic             overflow;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int start_cyc = 0;

    typedef struct {
        logic [31:0] r;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];

    vs_fp_dot #(.Q(Q), .LEN_W(LEN_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .length    (length),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Plain arithmetic: sum of 64-bit signed products, shift, clip.
    function automatic exp_t model(input int av[$], input int bv[$]);
        longint acc;
        longint s;
        exp_t   e;
        acc = 0;
        for (int i = 0; i < av.size(); i++)
            acc += longint'(av[i]) * longint'(bv[i]);
        s = acc >>> Q;
        if (s > 64'sd2147483647)       e = '{32'h7FFF_FFFF, 1'b1};
        else if (s < -64'sd2147483647) e = '{32'h8000_0001, 1'b1};
        else                           e = '{s[31:0], 1'b0};
        return e;
    endfunction

    function automatic int rand_op();
        int t;
        case ($urandom_range(0, 3))
            0: return int'($urandom());
            1: begin
                t = int'($urandom_range(0, 1 << 18));
                return t - (1 << 17);
            end
            2: return ($urandom_range(0, 1) == 1) ? int'(32'h7FFF_FFFF) : int'(32'h8000_0000);
            default: begin
                t = int'($urandom_range(0, 8)) - 4;
                return t <<< Q;
            end
        endcase
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge clock);
            if (reset_n) begin
                check("ready_valid_exclusive", 64'(in_ready & out_valid), 0);
                check("busy_vs_state", 64'(busy), 64'(in_ready | out_valid));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_valid", 64'(out_valid), 0);
                    end else begin
                        check("model_result", 64'(result), 64'(exp_q[0].r));
                        check("model_overflow", 64'(overflow), 64'(exp_q[0].ov));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic start_frame(input int len);
        check("idle_before_start", 64'(busy), 0);
        start     = 1'b1;
        length    = LEN_W'(len);
        start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input int a, input int b, input int gap, input bit pulse);
        bit done;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start    = pulse && (g == 0);
            length   = '0;
            @(posedge clock); #1;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        done     = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clock);
            done = in_ready;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check("beat_accepted", 64'(done), 1);
    endtask

    task automatic wait_result(input bit rnd, output logic [31:0] r, output logic ov, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        r   = '0;
        ov  = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clock);
            if (out_valid && lat < 0) lat = cyc - start_cyc;
            if (out_valid && out_ready) begin
                got = 1'b1;
                r   = result;
                ov  = overflow;
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        check("result_seen", 64'(got), 1);
    endtask

    task automatic run_frame(input int av[$], input int bv[$], input int max_gap, input bit rnd,
                             output logic [31:0] r, output logic ov, output int lat);
        exp_q.push_back(model(av, bv));
        start_frame(av.size());
        for (int i = 0; i < av.size(); i++)
            send_pair(av[i], bv[i], int'($urandom_range(0, max_gap)), 1'b0);
        wait_result(rnd, r, ov, lat);
    endtask

    initial begin
        int          ba[$];
        int          bb[$];
        int          av[$];
        int          bv[$];
        logic [31:0] r;
        logic        ov;
        int          lat;
        int          len;
        exp_t        e;

        fork
            compare_loop();
        join_none

        #2 reset_n = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 0);
        check("reset_in_ready", 64'(in_ready), 0);
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_result", 64'(result), 0);
        check("reset_overflow", 64'(overflow), 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;

        ba = '{'h8000, 'h10000, -'h8000};
        bb = '{'h8000, 'hC000, 'h4000};
        e  = model(ba, bb);
        check("model_pin_basic", 64'(e.r), 64'h0001_C000);

        run_frame(ba, bb, 0, 1'b0, r, ov, lat);
        check("basic_result", 64'(r), 64'h0001_C000);
        check("basic_overflow", 64'(ov), 0);
        check("basic_latency", 64'(lat), 4);

        av = '{int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF)};
        bv = av;
        e  = model(av, bv);
        check("model_pin_pos_sat", 64'(e.r), 64'h7FFF_FFFF);
        run_frame(av, bv, 0, 1'b0, r, ov, lat);
        check("pos_sat_result", 64'(r), 64'h7FFF_FFFF);
        check("pos_sat_overflow", 64'(ov), 1);

        av = '{int'(32'h7FFF_FFFF)};
        bv = '{int'(32'h8000_0000)};
        run_frame(av, bv, 0, 1'b0, r, ov, lat);
        check("neg_sat_result", 64'(r), 64'h8000_0001);
        check("neg_sat_overflow", 64'(ov), 1);

        av.delete();
        bv.delete();
        exp_q.push_back(model(av, bv));
        start_frame(0);
        check("zero_in_ready", 64'(in_ready), 0);
        wait_result(1'b0, r, ov, lat);
        check("zero_result", 64'(r), 0);
        check("zero_overflow", 64'(ov), 0);
        check("zero_latency", 64'(lat), 1);

        // Backpressure: input gaps, stalled consumer, stray starts.
        exp_q.push_back(model(ba, bb));
        out_ready = 1'b0;
        start_frame(3);
        send_pair(ba[0], bb[0], 0, 1'b0);
        send_pair(ba[1], bb[1], 2, 1'b1);
        send_pair(ba[2], bb[2], 2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            start  = (i == 2);
            length = '0;
            @(negedge clock);
            check("bp_hold_valid", 64'(out_valid), 1);
            check("bp_hold_result", 64'(result), 64'h0001_C000);
            check("bp_hold_overflow", 64'(overflow), 0);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        start     = 1'b1;
        length    = LEN_W'(1);
        @(negedge clock);
        check("bp_valid_at_handshake", 64'(out_valid), 1);
        @(posedge clock); #1;
        start     = 1'b0;
        out_ready = 1'b0;
        check("bp_idle_busy", 64'(busy), 0);
        check("bp_idle_out_valid", 64'(out_valid), 0);
        check("bp_idle_in_ready", 64'(in_ready), 0);

        // Reset in the middle of a frame.
        av = '{'h4000_0000, 'h4000_0000, 'h1234, 'h5678};
        bv = '{'h4000_0000, 'h4000_0000, 'h1111, 'h2222};
        exp_q.push_back(model(av, bv));
        start_frame(4);
        send_pair(av[0], bv[0], 0, 1'b0);
        send_pair(av[1], bv[1], 0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 0);
        check("abort_in_ready", 64'(in_ready), 0);
        check("abort_out_valid", 64'(out_valid), 0);
        check("abort_result", 64'(result), 0);
        check("abort_overflow", 64'(overflow), 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        av = '{'h8000};
        bv = '{'h8000};
        run_frame(av, bv, 0, 1'b0, r, ov, lat);
        check("post_reset_result", 64'(r), 64'h0000_8000);
        check("post_reset_overflow", 64'(ov), 0);

        // Randomized frames with input gaps and a random consumer.
        for (int f = 0; f < 40; f++) begin
            av.delete();
            bv.delete();
            len = int'($urandom_range(0, 8));
            for (int i = 0; i < len; i++) begin
                av.push_back(rand_op());
                bv.push_back(rand_op());
            end
            run_frame(av, bv, 2, 1'b1, r, ov, lat);
        end

        repeat (2) @(posedge clock);
        check("queue_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
